// File: rtl/mcu_spi_pkg.sv
// rtl/mcu_spi_pkg.sv - shared constants, packet length, FSM type and CRC-8 step (MCU_SPI_CRC_EN)
package mcu_spi_pkg;
    localparam logic [7:0] HEADER_DEFAULT   = 8'hAA;
    localparam int         BYTES_PER_SENSOR = 15;
    localparam int         QUAT_W           = 64;
    localparam int         GYRO_W           = 48;

    localparam int FLAG_QUAT_VALID = 0;
    localparam int FLAG_GYRO_VALID = 1;
    localparam int FLAG_OVERRUN    = 2;

`ifdef MCU_SPI_CRC_EN
    localparam int CRC_BYTES = 1;

    // CRC-8, poly 0x07, one data byte per call, MSB first
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++)
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        return c;
    endfunction
`else
    localparam int CRC_BYTES = 0;
`endif

    typedef enum logic {IDLE, READY} fsm_t;

    function automatic int packet_len(input int num_sensors);
        return 2 + BYTES_PER_SENSOR * num_sensors + CRC_BYTES;
    endfunction
endpackage

// File: rtl/mcu_spi_packet_tx_sync.sv
// rtl/mcu_spi_packet_tx_sync.sv - spi_pin_sync: multi-flop synchroniser with rise/fall detect
module spi_pin_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], pin};
            prev  <= chain[STAGES-1];
        end
    end

    assign level = chain[STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;
endmodule

// File: rtl/mcu_spi_packet_tx.sv
// rtl/mcu_spi_packet_tx.sv - SPI mode-0 slave packet transmitter of snapshotted sensor data
// Optional CRC-8 trailer byte when MCU_SPI_CRC_EN is defined.
module mcu_spi_packet_tx
    import mcu_spi_pkg::*;
#(
    parameter int         NUM_SENSORS = 2,
    parameter logic [7:0] HEADER      = HEADER_DEFAULT,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          sck,
    input  logic                          sdi,
    output logic                          sdo,
    input  logic                          load,
    output logic                          done,
    input  logic [NUM_SENSORS-1:0]        quat_valid,
    input  logic [NUM_SENSORS-1:0]        gyro_valid,
    input  logic [QUAT_W*NUM_SENSORS-1:0] quat_data,
    input  logic [GYRO_W*NUM_SENSORS-1:0] gyro_data,
    output logic [7:0]                    rx_byte
);
    localparam int                LEN      = packet_len(NUM_SENSORS);
    localparam int                BITS     = 8 * LEN;
    localparam int                IDX_W    = $clog2(BITS + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(BITS);
    localparam int                CH_BITS  = 8 * BYTES_PER_SENSOR;

    fsm_t              state;
    logic [BITS-1:0]   pkt;
    logic [BITS-1:0]   pkt_next;
    logic [IDX_W-1:0]  bit_idx;
    logic [7:0]        seq;
    logic              overrun;
    logic              pending;
    logic              has_valid_q;
    logic              new_data;
    logic [7:0]        rx_shift;
    logic [2:0]        rx_cnt;
    logic [7:0]        flags;
    logic              sck_rise, sck_fall, sdi_s, load_rise;
    logic              unused_sck_lvl, unused_sdi_rise, unused_sdi_fall;
    logic              unused_load_lvl, unused_load_fall;

    spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_sck (
        .clk(clk), .rst_n(rst_n), .pin(sck),
        .level(unused_sck_lvl), .rise(sck_rise), .fall(sck_fall)
    );
    spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_sdi (
        .clk(clk), .rst_n(rst_n), .pin(sdi),
        .level(sdi_s), .rise(unused_sdi_rise), .fall(unused_sdi_fall)
    );
    spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_load (
        .clk(clk), .rst_n(rst_n), .pin(load),
        .level(unused_load_lvl), .rise(load_rise), .fall(unused_load_fall)
    );

    assign new_data = (|quat_valid | |gyro_valid) & ~has_valid_q;

`ifdef MCU_SPI_CRC_EN
    logic [7:0] crc;
`endif

    // Packet image laid out MSB-first so byte 0 leaves the shifter first
    always_comb begin
        pkt_next = '0;
        flags    = '0;
        pkt_next[BITS-1 -: 16] = {HEADER, seq};
        for (int k = 0; k < NUM_SENSORS; k++) begin
            flags                  = '0;
            flags[FLAG_QUAT_VALID] = quat_valid[k];
            flags[FLAG_GYRO_VALID] = gyro_valid[k];
            flags[FLAG_OVERRUN]    = overrun;
            pkt_next[BITS-17-CH_BITS*k -: CH_BITS] =
                {quat_data[QUAT_W*k +: QUAT_W], gyro_data[GYRO_W*k +: GYRO_W], flags};
        end
`ifdef MCU_SPI_CRC_EN
        crc = 8'h00;
        for (int b = 0; b < LEN - 1; b++)
            crc = crc8_step(crc, pkt_next[BITS-1-8*b -: 8]);
        pkt_next[7:0] = crc;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pkt         <= '0;
            bit_idx     <= '0;
            seq         <= 8'h00;
            overrun     <= 1'b0;
            pending     <= 1'b0;
            has_valid_q <= 1'b0;
            rx_shift    <= 8'h00;
            rx_cnt      <= 3'd0;
            rx_byte     <= 8'h00;
        end else begin
            has_valid_q <= |quat_valid | |gyro_valid;
            case (state)
                IDLE: begin
                    if (new_data || pending) begin
                        pkt     <= pkt_next;
                        seq     <= seq + 8'd1;
                        overrun <= 1'b0;
                        pending <= 1'b0;
                        bit_idx <= '0;
                        rx_cnt  <= 3'd0;
                        state   <= READY;
                    end
                end
                READY: begin
                    if (load_rise) begin
                        // an event landing on the ack is carried into the next packet
                        pending <= new_data;
                        bit_idx <= '0;
                        state   <= IDLE;
                    end else begin
                        if (new_data)
                            overrun <= 1'b1;
                        if (sck_fall && bit_idx != LAST_IDX) begin
                            bit_idx <= bit_idx + 1'b1;
                            pkt     <= {pkt[BITS-2:0], 1'b0};
                        end
                        if (sck_rise) begin
                            rx_shift <= {rx_shift[6:0], sdi_s};
                            rx_cnt   <= rx_cnt + 3'd1;
                            if (rx_cnt == 3'd7)
                                rx_byte <= {rx_shift[6:0], sdi_s};
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign done = (state == READY);
    assign sdo  = (state == READY) ? pkt[BITS-1] : 1'b0;
endmodule
